// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and constants for the iterative multiply/divide
//               unit (sequencer state encoding, op encoding, default width).
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'd0;
  localparam logic [1:0] OP_MULT  = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;
  localparam logic [1:0] OP_DIV   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration of the multiply/divide datapath.
//               Multiply: MSB-first shift-add, acc' = 2*acc + bit*opnd.
//               Divide  : restoring shift-subtract; acc = {remainder, quotient},
//                         the next dividend bit enters the remainder LSB.
//               The divide path exists only when MULDIV_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  input  logic               i_bit,
`ifdef MULDIV_DIV_EN
  input  logic               i_div,
`endif
  output logic [2*WIDTH-1:0] o_acc
);

  logic [2*WIDTH-1:0] w_mul;

  // Product grows from the multiplier MSB downwards, so after WIDTH steps
  // the accumulator holds the full double-width product.
  assign w_mul = {i_acc[2*WIDTH-2:0], 1'b0}
               + (i_bit ? {{WIDTH{1'b0}}, i_opnd} : {(2*WIDTH){1'b0}});

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  // The remainder is always below the divisor, so both the restored and the
  // subtracted value fit back into WIDTH bits. A zero divisor always
  // "subtracts", which leaves the dividend in the remainder and all ones in
  // the quotient.
  assign w_trial = {i_acc[2*WIDTH-1:WIDTH], i_bit};
  assign w_ge    = (w_trial >= {1'b0, i_opnd});
  assign w_diff  = w_trial - {1'b0, i_opnd};

  assign o_acc = i_div ? {(w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                          i_acc[WIDTH-2:0], w_ge}
                       : w_mul;
`else
  assign o_acc = w_mul;
`endif

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative multiply/divide unit with private HI/LO registers.
//               One bit per cycle; result visible WIDTH+1 cycles after start.
//               Raises stall while busy if the instruction stream reads HI/LO
//               or presents another start.
//               Build option: MULDIV_DIV_EN enables DIVU/DIV (ops 2/3); without
//               it those starts are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_srca,
  input  logic [WIDTH-1:0] i_srcb,
  input  logic             i_rd_hi,
  input  logic             i_rd_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_stall
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   w_step_acc;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     r_opnd;
  logic [WIDTH-1:0]     r_bits;
  logic                 r_neg_q;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;
  logic                 w_is_mul;
  logic                 w_is_div;
  logic                 w_signed;
  logic                 w_legal;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
`ifdef MULDIV_DIV_EN
  logic                 r_div;
  logic                 r_dz;
  logic                 r_neg_r;
`endif

  assign w_is_mul = (i_op == OP_MULTU) || (i_op == OP_MULT);
  assign w_is_div = (i_op == OP_DIVU)  || (i_op == OP_DIV);
  assign w_signed = (i_op == OP_MULT)  || (i_op == OP_DIV);
`ifdef MULDIV_DIV_EN
  assign w_legal  = w_is_mul | w_is_div;
`else
  assign w_legal  = w_is_mul & ~w_is_div;
`endif
  assign w_accept = (r_state == ST_IDLE) & i_start & w_legal;

  // Signed ops run on magnitudes; sign is restored in FIN.
  assign w_a_mag = (w_signed & i_srca[WIDTH-1]) ? -i_srca : i_srca;
  assign w_b_mag = (w_signed & i_srcb[WIDTH-1]) ? -i_srcb : i_srcb;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .i_bit  (r_bits[WIDTH-1]),
`ifdef MULDIV_DIV_EN
    .i_div  (r_div),
`endif
    .o_acc  (w_step_acc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode plus combinational busy/stall.
  always_comb begin
    w_next = r_state;
    o_busy = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_RUN;
      ST_RUN:  if (r_cnt == LAST) w_next = ST_FIN;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    o_stall = o_busy & (i_rd_hi | i_rd_lo | i_start);
  end

  // Sign correction of the finished accumulator into HI/LO values.
  always_comb begin
    w_prod   = r_neg_q ? -r_acc : r_acc;
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (r_div) begin
      // Divide by zero reports the raw all-ones quotient and latched dividend.
      w_res_lo = (r_neg_q & ~r_dz) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_res_hi = (r_neg_r & ~r_dz) ? -r_acc[2*WIDTH-1:WIDTH]
                                   : r_acc[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // Operand latch, per-step iteration, and HI/LO write at FIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_bits  <= '0;
      r_neg_q <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_div   <= 1'b0;
      r_dz    <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      r_done <= (r_state == ST_FIN);
      if (w_accept) begin
        r_acc   <= '0;
        r_cnt   <= '0;
        r_neg_q <= w_signed & (i_srca[WIDTH-1] ^ i_srcb[WIDTH-1]);
`ifdef MULDIV_DIV_EN
        r_div   <= w_is_div;
        r_dz    <= (i_srcb == '0);
        r_neg_r <= w_signed & i_srca[WIDTH-1];
        r_opnd  <= w_is_div ? w_b_mag : w_a_mag;
        r_bits  <= w_is_div ? w_a_mag : w_b_mag;
`else
        r_opnd  <= w_a_mag;
        r_bits  <= w_b_mag;
`endif
      end else if (r_state == ST_RUN) begin
        r_acc  <= w_step_acc;
        r_bits <= {r_bits[WIDTH-2:0], 1'b0};
        r_cnt  <= r_cnt + CW'(1);
      end else if (r_state == ST_FIN) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer: directed vector
//               table, random ops against an arithmetic reference model, and
//               hand sequences for stall, queued start and mid-op reset.
//               Honours MULDIV_DIV_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic        rd_hi = 1'b0;
  logic        rd_lo = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [10];

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_start (start),
    .i_op    (op),
    .i_srca  (srca),
    .i_srcb  (srcb),
    .i_rd_hi (rd_hi),
    .i_rd_lo (rd_lo),
    .o_hi    (hi),
    .o_lo    (lo),
    .o_busy  (busy),
    .o_done  (done),
    .o_stall (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain arithmetic reference: {hi, lo} for one operation.
  function automatic logic [63:0] ref_model(input logic [1:0] f_op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f_op)
      2'd0: res = {32'd0, a} * {32'd0, b};
      2'd1: res = 64'(sa * sb);
      2'd2: res = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: begin
        if (b == 0) begin
          q   = (sa < 0) ? -sa : sa;
          res = {q[31:0], 32'hFFFFFFFF};
        end else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  function automatic bit executes(input logic [1:0] f_op);
    bit e;
    e = 1'b1;
`ifndef MULDIV_DIV_EN
    if (f_op[1]) e = 1'b0;
`endif
    return e;
  endfunction

  // Issue one op, wait for its result, check timing and HI/LO.
  task automatic do_op(input logic [1:0] t_op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input string tag);
    bit ex;
    int k;
    ex = executes(t_op);
    @(negedge clk);
    start = 1'b1; op = t_op; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy"}, 64'(busy), 64'(ex));
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (ex) check({tag, " latency"}, 64'(k), 64'd33);
    else    check({tag, " no done"}, 64'(done), 64'd0);
    check({tag, " hilo"}, {hi, lo}, ex ? exp : {cur_hi, cur_lo});
    check({tag, " busy end"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({tag, " done pulse"}, 64'(done), 64'd0);
    if (ex) begin
      cur_hi = exp[63:32];
      cur_lo = exp[31:0];
    end
  endtask

  initial begin
    int          k;
    int          bad;
    logic [1:0]  r_op;
    logic [31:0] ra, rb;
    logic [63:0] exp;

    vecs[0] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{2'd2, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[2] = '{2'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[3] = '{2'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[5] = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{2'd1, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[7] = '{2'd2, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[8] = '{2'd0, 32'd0,        32'h12345678, 32'd0,        32'd0};
    vecs[9] = '{2'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};

    // Reset state.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    rd_lo = 1'b1;
    #1 check("idle stall", 64'(stall), 64'd0);
    rd_lo = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 10; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, $sformatf("vec%0d", i));

    // Randomized ops against the reference model.
    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom_range(0, 3));
      ra   = $urandom;
      rb   = (i % 6 == 5) ? 32'd0 : ((i % 4 == 3) ? 32'($urandom_range(1, 300)) : $urandom);
      do_op(r_op, ra, rb, ref_model(r_op, ra, rb), $sformatf("rnd%0d", i));
    end

    // Start and read in the same idle cycle: no stall, old HI/LO visible.
    @(negedge clk);
    start = 1'b1; op = 2'd0; srca = 32'h12345678; srcb = 32'h9ABCDEF0; rd_hi = 1'b1;
    #1 check("idle start stall", 64'(stall), 64'd0);
    check("idle read old", {hi, lo}, {cur_hi, cur_lo});
    @(negedge clk);
    start = 1'b0; rd_hi = 1'b0;
    exp = ref_model(2'd0, 32'h12345678, 32'h9ABCDEF0);
    // rd_lo from 5 cycles in, then a queued start holds the stall.
    k = 0; bad = 0;
    while (busy && k < 40) begin
      if (k == 5)  rd_lo = 1'b1;
      if (k == 10) begin
        rd_lo = 1'b0; start = 1'b1; op = 2'd0; srca = 32'd7; srcb = 32'd6;
      end
      #1;
      if (k >= 5 && !stall) bad++;
      if (k < 5 && stall) bad++;
      @(negedge clk);
      k++;
    end
    check("stall while busy", 64'(bad), 64'd0);
    check("stall release cycle", 64'(k), 64'd33);
    check("stall free lo", 64'(lo), {32'd0, exp[31:0]});
    check("stall free hi", 64'(hi), {32'd0, exp[63:32]});
    check("stall low idle", 64'(stall), 64'd0);
    check("stall done", 64'(done), 64'd1);
    @(negedge clk);
    start = 1'b0;
    check("queued start accepted", 64'(busy), 64'd1);
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("queued latency", 64'(k), 64'd33);
    check("queued result", {hi, lo}, 64'd42);

    // Reset at RUN step 10 aborts without a write.
    @(negedge clk);
    start = 1'b1; op = 2'd0; srca = 32'hFFFFFFFF; srcb = 32'h0000FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort hilo", {hi, lo}, 64'd0);
    bad = 0;
    for (int i = 0; i < 36; i++) begin
      if (done || busy) bad++;
      @(negedge clk);
    end
    check("abort no done", 64'(bad), 64'd0);
    cur_hi = '0; cur_lo = '0;
    do_op(2'd0, 32'd7, 32'd6, 64'd42, "post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide unit with its own HI/LO registers, placed beside the single-cycle ALU in the datapath. It takes over the `mult`/`multu` (and optionally `div`/`divu`) path so the ALU no longer needs a combinational 64-bit product. The unit accepts one operation per start pulse, runs it one bit per cycle, and writes HI/LO. While busy it raises `stall` toward the program counter when the instruction stream needs the result or a new operation.

## Interface
- `WIDTH`, default 32: operand width; HI/LO are each `WIDTH` bits.
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: issue the operation in `op` with operands `srca`/`srcb`.
- `op`, in, 2: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV.
- `srca`, in, WIDTH: multiplicand or dividend (rs).
- `srcb`, in, WIDTH: multiplier or divisor (rt).
- `rd_hi`, in, 1: `mfhi` in the current instruction.
- `rd_lo`, in, 1: `mflo` in the current instruction.
- `hi`, out, WIDTH: HI register.
- `lo`, out, WIDTH: LO register.
- `busy`, out, 1: an operation is in flight.
- `done`, out, 1: one-cycle pulse; `hi`/`lo` hold a new result this cycle.
- `stall`, out, 1: the PC and register write must hold this cycle.

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE, `start`=1, legal `op`:
  - latch the magnitudes of the operands (absolute values for MULT/DIV, raw values otherwise);
  - latch the op and the result sign flags;
  - clear the 64-bit accumulator and set step counter = 0;
  - go to RUN.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. The counter increments each step. After step WIDTH (counter = WIDTH-1 at the edge), go to FIN.
- FIN: apply sign correction and write HI/LO, then go to IDLE.
  - Multiply: `{hi,lo}` = 64-bit product, negated (two's complement) for MULT when the operand signs differ.
  - Divide: `lo` = quotient, `hi` = remainder.
  - DIV sign rules: the quotient is negated when the signs differ; the remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- Divide by zero, both signednesses: lo = 0xFFFFFFFF, hi = srca as latched, with no sign correction. The full WIDTH steps still run.
- `busy` = (state != IDLE).
- `stall` = `busy` & (`rd_hi` | `rd_lo` | `start`).
- A `start` received while busy is ignored. The datapath keeps presenting it under `stall` and it is accepted in the first IDLE cycle.
- A `start` and an `rd_*` in the same IDLE cycle do not stall. The read returns the old HI/LO.
- `hi`/`lo` change only at the FIN edge or on reset.

## Timing
- Reset: state IDLE, `hi`=0, `lo`=0, `done`=0, `busy`=0, `stall`=0.
- Reset mid-operation aborts the operation with no HI/LO write.
- Cycle-level sequence for a start sampled at edge E0:
  - `busy`=1 after E0;
  - RUN occupies edges E1..E32;
  - FIN edge E33 writes HI/LO and drives `busy` to 0;
  - `done`=1 for exactly the cycle after E33.
- Latency from start to a visible result: 33 cycles (WIDTH+1). Throughput: one operation per 34 cycles.
- `done` is registered. `busy` and `stall` decode combinationally from the state register and inputs.

## Configuration
- `MULDIV_DIV_EN` defined: ops 2 and 3 execute as specified.
- `MULDIV_DIV_EN` undefined: the divide datapath and the remainder sign logic are not compiled.
  - A `start` with `op[1]`=1 is ignored: no state change, no `busy`, no `done`, HI/LO unchanged.
  - Multiply behaviour and timing are identical in both builds.

## Structure
- Package `muldiv_pkg` holds:
  - the state enum (IDLE/RUN/FIN);
  - the op encoding constants (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - the default WIDTH.
- Sub-module `muldiv_step` is combinational. Given the accumulator, operand and op, it returns the next accumulator for one iteration (add-shift or trial-subtract-shift). The sequencer holds all registers and the FSM.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, one-cycle `done`.
- MULT 0xFFFFFFFE (-2) × 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100.
- Without the macro, DIVU start -> `busy` stays 0 and HI/LO are unchanged.
- `rd_lo` asserted 5 cycles after a MULTU start -> `stall` held high until `busy` drops. In the first non-busy cycle `lo` shows the new product and `stall`=0. A second start while busy -> `stall`=1, and it is accepted on the first IDLE cycle.
- Reset asserted at RUN step 10 -> next cycle IDLE, hi=lo=0, no `done`. A following MULTU 7×6 -> lo=42, hi=0.
